alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter that shares the single-cycle datapath's `alu` between two independent requesters, such as the main execute path and an address/branch helper unit. Each requester presents an operation on a valid/ready channel. The arbiter drives the `alu` operand and control inputs combinationally from the winning requester. It captures `ALUResult`/`Zero` into a one-entry response register, tagged with the requester id, and holds it until the consumer accepts it.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must match `alu`.
- `CTRL_W`, 3: `ALUControl` width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Req0Valid`  in  1  requester 0 has an operation.
- `Req0Ready`  out  1  requester 0 operation accepted this cycle when high with `Req0Valid`.
- `Req0SrcA`, `Req0SrcB`  in  WIDTH  requester 0 operands.
- `Req0Control`  in  CTRL_W  requester 0 ALU opcode.
- `Req1Valid`, `Req1Ready`, `Req1SrcA`, `Req1SrcB`, `Req1Control`: same as the requester 0 ports, for requester 1.
- `SrcA`, `SrcB`  out  WIDTH  to `alu`.
- `ALUControl`  out  CTRL_W  to `alu`.
- `ALUResult`  in  WIDTH  from `alu` (combinational).
- `Zero`  in  1  from `alu`.
- `RespValid`  out  1  response register holds a result.
- `RespReady`  in  1  consumer takes the response.
- `RespId`  out  1  requester that issued the held result.
- `RespResult`  out  WIDTH  registered ALU result.
- `RespZero`  out  1  registered Zero flag.

## Operation
- ALU opcodes pass through unmodified:
  - 000 add, 001 sub, 010 and, 011 or, 101 slt (signed).
  - Any other code makes the `alu` return 0 with Zero=1. The arbiter does not filter codes.
- Slot free: `SlotFree = !RespValid || RespReady`.
- Grant, evaluated combinationally each cycle:
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to `LastGrant` wins.
  - Neither valid: no grant. `SrcA`/`SrcB`/`ALUControl` then drive requester 0's inputs (don't care).
- Ready: `ReqNReady = grantN && SlotFree && !reset`. At most one Ready is high per cycle.
- On an accept (Valid && Ready) at a rising edge:
  - `RespResult <= ALUResult`, `RespZero <= Zero`, `RespId <= granted id`, `RespValid <= 1`, `LastGrant <= granted id`.
- Drain: `RespValid && RespReady` with no accept in the same cycle gives `RespValid <= 0`. The other response fields hold their last value.
- Simultaneous drain and accept: the register is overwritten with the new result and `RespValid` stays 1. This gives full throughput of one op per cycle.
- Backpressure: while `RespValid && !RespReady`, both Ready signals are 0. The response fields are stable, and requester inputs may change freely.
- Fairness: with both requesters continuously valid and no backpressure, grants alternate 0,1,0,1,…. Neither requester waits more than one accepted op of the other.
- Requesters must hold Valid and their operands until Ready. A requester that drops Valid before acceptance is not serviced, and no state changes.

## Timing
- Reset values: `RespValid=0`, `RespId=0`, `RespResult=0`, `RespZero=0`, `LastGrant=1` (requester 0 wins first contention). `Req0Ready=Req1Ready=0` while `reset` is high.
- Latency: an op accepted at edge N appears on `Resp*` after edge N, i.e. visible in cycle N+1.
- Ready depends combinationally on Valid and RespReady. No combinational path runs from `Resp*` outputs to the `alu` inputs.
- Reset asserted mid-operation (response held, or a request pending): at the next edge all state returns to reset values. The held response is discarded, and a pending request is not accepted in the reset cycle.
- `LastGrant` changes only on an accept. Idle cycles and backpressured cycles do not rotate priority.

## Test plan
- Single add: Req0 valid, 00001234+00005678, op 000, RespReady=1 → Req0Ready=1 in the same cycle; next cycle RespValid=1, RespId=0, RespResult=000068AC, RespZero=0.
- Contention after reset: both valid, Req0 sub 1234−1234, Req1 or FFFF0000|0000FFFF, RespReady=1 → first response id 0, result 0, Zero=1; second id 1, result FFFFFFFF; no idle cycle between them.
- Sustained contention: both valid for 6 cycles, no backpressure → RespId sequence 0,1,0,1,0,1 and one response per cycle.
- Backpressure: response held with RespReady=0 for 3 cycles while both requesters are valid → both Ready=0 and Resp* stable; when RespReady=1 the held result drains and a new op is accepted in the same edge.
- Signed slt plus undefined code: Req1 slt FFFFFF33 vs FFFFFFEE → result 00000001; then op 110 on 12341234/ABCDABCD → result 0, Zero=1.
- Reset mid-operation: response held, reset pulsed for 1 cycle with both requesters valid → RespValid=0 after the edge and no accept during reset; the first accept after reset grants requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready
// requesters, with a one-entry tagged response register toward the consumer.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [WIDTH-1:0]  Req0SrcA,
  input  logic [WIDTH-1:0]  Req0SrcB,
  input  logic [CTRL_W-1:0] Req0Control,
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [WIDTH-1:0]  Req1SrcA,
  input  logic [WIDTH-1:0]  Req1SrcB,
  input  logic [CTRL_W-1:0] Req1Control,
  output logic [WIDTH-1:0]  SrcA,
  output logic [WIDTH-1:0]  SrcB,
  output logic [CTRL_W-1:0] ALUControl,
  input  logic [WIDTH-1:0]  ALUResult,
  input  logic              Zero,
  output logic              RespValid,
  input  logic              RespReady,
  output logic              RespId,
  output logic [WIDTH-1:0]  RespResult,
  output logic              RespZero
);

  logic             last_grant_q, last_grant_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q,    resp_id_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_zero_q,  resp_zero_d;

  logic any_valid;
  logic grant_id;
  logic slot_free;
  logic accept;

  // Grant depends only on the request valids and last_grant_q, so no path
  // runs from the response register back into the ALU operand muxes.
  always_comb begin
    any_valid = Req0Valid || Req1Valid;
    if (Req0Valid && Req1Valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = Req1Valid;
    end
    slot_free = !resp_valid_q || RespReady;
    accept    = any_valid && slot_free && !reset;
  end

  assign Req0Ready  = accept && !grant_id;
  assign Req1Ready  = accept &&  grant_id;

  assign SrcA       = grant_id ? Req1SrcA    : Req0SrcA;
  assign SrcB       = grant_id ? Req1SrcB    : Req0SrcB;
  assign ALUControl = grant_id ? Req1Control : Req0Control;

  // NOTE: every _d gets its hold value first so no path through this block
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    last_grant_d  = last_grant_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    if (accept) begin
      // A same-cycle drain is covered here too: the slot is simply overwritten.
      last_grant_d  = grant_id;
      resp_valid_d  = 1'b1;
      resp_id_d     = grant_id;
      resp_result_d = ALUResult;
      resp_zero_d   = Zero;
    end else if (resp_valid_q && RespReady) begin
      resp_valid_d  = 1'b0;
    end
  end

  // NOTE: non-blocking assignments make every register sample its _d from the
  // same pre-edge state, independent of the order of statements.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q  <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
    end else begin
      last_grant_q  <= last_grant_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
    end
  end

  assign RespValid  = resp_valid_q;
  assign RespId     = resp_id_q;
  assign RespResult = resp_result_q;
  assign RespZero   = resp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU on the shared port and a
// scoreboard of expected responses popped whenever the consumer takes one.
module tb_alu_arbiter;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 3;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] res;
    logic             zero;
  } resp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              Req0Valid, Req0Ready;
  logic [WIDTH-1:0]  Req0SrcA, Req0SrcB;
  logic [CTRL_W-1:0] Req0Control;
  logic              Req1Valid, Req1Ready;
  logic [WIDTH-1:0]  Req1SrcA, Req1SrcB;
  logic [CTRL_W-1:0] Req1Control;
  logic [WIDTH-1:0]  SrcA, SrcB;
  logic [CTRL_W-1:0] ALUControl;
  logic [WIDTH-1:0]  ALUResult;
  logic              Zero;
  logic              RespValid, RespReady, RespId, RespZero;
  logic [WIDTH-1:0]  RespResult;

  int    checks   = 0;
  int    failures = 0;
  resp_t sb[$];
  resp_t mon_exp;
  int    k0, k1;

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0SrcA(Req0SrcA),
    .Req0SrcB(Req0SrcB), .Req0Control(Req0Control),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1SrcA(Req1SrcA),
    .Req1SrcB(Req1SrcB), .Req1Control(Req1Control),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .Zero(Zero),
    .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId),
    .RespResult(RespResult), .RespZero(RespZero)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_alu(input logic [CTRL_W-1:0] ctrl,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (ctrl)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b101:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: r = '0;
    endcase
    return {(r == '0), r};
  endfunction

  always_comb {Zero, ALUResult} = ref_alu(ALUControl, SrcA, SrcB);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [CTRL_W-1:0] ctrl,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = ref_alu(ctrl, a, b);
    sb.push_back('{id: id, res: r[WIDTH-1:0], zero: r[WIDTH]});
  endtask

  task automatic set_req0(input logic v, input logic [CTRL_W-1:0] c,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    Req0Valid = v; Req0Control = c; Req0SrcA = a; Req0SrcB = b;
  endtask

  task automatic set_req1(input logic v, input logic [CTRL_W-1:0] c,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    Req1Valid = v; Req1Control = c; Req1SrcA = a; Req1SrcB = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Consumer side: every taken response must match the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else if (RespValid && RespReady) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", {31'b0, RespId, RespResult}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_exp = sb.pop_front();
        check("resp", {30'b0, RespId, RespResult, RespZero}, {30'b0, mon_exp});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset: a pending request must not be accepted.
    reset = 1'b1; RespReady = 1'b1;
    set_req0(1'b1, 3'b000, 32'd1, 32'd2);
    set_req1(1'b0, 3'b000, '0, '0);
    @(negedge clk);
    check("rst_ready0", Req0Ready, 0);
    check("rst_resp", {RespValid, RespId, RespZero, RespResult}, 0);
    next_cycle();

    // Contention after reset: requester 0 first, then 1, back to back.
    reset = 1'b0;
    set_req0(1'b1, 3'b001, 32'h1234, 32'h1234);
    set_req1(1'b1, 3'b011, 32'hFFFF0000, 32'h0000FFFF);
    push(0, 3'b001, 32'h1234, 32'h1234);
    push(1, 3'b011, 32'hFFFF0000, 32'h0000FFFF);
    @(negedge clk);
    check("cont_rdy", {Req0Ready, Req1Ready}, 2'b10);
    next_cycle();
    Req0Valid = 1'b0;
    @(negedge clk);
    check("cont_rdy2", {Req0Ready, Req1Ready}, 2'b01);
    check("cont_first", {RespValid, RespId, RespZero}, 3'b101);
    next_cycle();
    Req1Valid = 1'b0;
    @(negedge clk);
    check("cont_second", {RespValid, RespId}, 2'b11);
    next_cycle();

    // Sustained contention: strict alternation, one response per cycle.
    k0 = 0; k1 = 0;
    for (int i = 0; i < 6; i++) begin
      set_req0(1'b1, 3'b000, k0 + 1, 32'd7);
      set_req1(1'b1, 3'b001, 32'd100, k1);
      if (i % 2 == 0) push(0, 3'b000, k0 + 1, 32'd7);
      else            push(1, 3'b001, 32'd100, k1);
      @(negedge clk);
      check("rr_rdy", {Req0Ready, Req1Ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) check("rr_valid", RespValid, 1);
      if (i % 2 == 0) k0++; else k1++;
      next_cycle();
    end
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    @(negedge clk);
    check("rr_last", {RespValid, RespId}, 2'b11);
    next_cycle();

    // Single add.
    set_req0(1'b1, 3'b000, 32'h1234, 32'h5678);
    push(0, 3'b000, 32'h1234, 32'h5678);
    @(negedge clk);
    check("add_rdy", {Req0Ready, Req1Ready}, 2'b10);
    next_cycle();
    Req0Valid = 1'b0;
    @(negedge clk);
    check("add_resp", {RespValid, RespId, RespZero, RespResult}, {3'b100, 32'h000068AC});
    next_cycle();

    // Backpressure: held response, both requesters stalled for 3 cycles.
    RespReady = 1'b0;
    set_req0(1'b1, 3'b011, 32'd3, 32'd4);
    push(0, 3'b011, 32'd3, 32'd4);
    @(negedge clk);
    check("bp_accept", Req0Ready, 1);
    next_cycle();
    set_req0(1'b1, 3'b000, 32'd5, 32'd6);
    set_req1(1'b1, 3'b010, 32'hF0, 32'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall", {Req0Ready, Req1Ready}, 2'b00);
      check("bp_hold", {RespValid, RespId, RespZero, RespResult}, {3'b100, 32'd7});
      next_cycle();
    end
    RespReady = 1'b1;
    push(1, 3'b010, 32'hF0, 32'h3C);
    @(negedge clk);
    check("bp_release", {Req0Ready, Req1Ready}, 2'b01);
    next_cycle();
    Req1Valid = 1'b0;
    push(0, 3'b000, 32'd5, 32'd6);
    @(negedge clk);
    check("bp_after", {Req0Ready, RespValid, RespId}, 3'b111);
    next_cycle();
    Req0Valid = 1'b0;

    // Signed slt, then an undefined opcode.
    set_req1(1'b1, 3'b101, 32'hFFFFFF33, 32'hFFFFFFEE);
    push(1, 3'b101, 32'hFFFFFF33, 32'hFFFFFFEE);
    @(negedge clk);
    check("slt_rdy", Req1Ready, 1);
    next_cycle();
    Req1Valid = 1'b0;
    set_req0(1'b1, 3'b110, 32'h12341234, 32'hABCDABCD);
    push(0, 3'b110, 32'h12341234, 32'hABCDABCD);
    @(negedge clk);
    check("slt_resp", {RespValid, RespId, RespResult}, {2'b11, 32'd1});
    next_cycle();
    Req0Valid = 1'b0;
    @(negedge clk);
    check("undef_resp", {RespValid, RespZero, RespResult}, {2'b11, 32'd0});
    next_cycle();

    // Reset mid-operation: held response discarded, priority restored.
    RespReady = 1'b0;
    set_req0(1'b1, 3'b000, 32'd1, 32'd1);
    push(0, 3'b000, 32'd1, 32'd1);
    next_cycle();
    reset = 1'b1;
    set_req0(1'b1, 3'b001, 32'd9, 32'd2);
    set_req1(1'b1, 3'b011, 32'd8, 32'd1);
    @(negedge clk);
    check("mid_rst_rdy", {Req0Ready, Req1Ready}, 2'b00);
    next_cycle();
    reset = 1'b0; RespReady = 1'b1;
    push(0, 3'b001, 32'd9, 32'd2);
    push(1, 3'b011, 32'd8, 32'd1);
    @(negedge clk);
    check("mid_rst_state", {RespValid, RespId, RespZero, RespResult}, 0);
    check("mid_rst_grant", {Req0Ready, Req1Ready}, 2'b10);
    next_cycle();
    Req0Valid = 1'b0;
    next_cycle();
    Req1Valid = 1'b0;

    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
